// File: rtl/ysyx_00000000_lsu_if.sv
// rtl/ysyx_00000000_lsu_if.sv - AXI-style memory bus between the LSU and the core bridge
interface ysyx_00000000_lsu_if;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;

    modport master (
        output arvalid, araddr, arsize, rready,
        output awvalid, awaddr, wvalid, wdata, wstrb, bready,
        input  arready, rvalid, rdata, rresp,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  arvalid, araddr, arsize, rready,
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
        output arready, rvalid, rdata, rresp,
        output awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/ysyx_00000000_lsu.sv
// rtl/ysyx_00000000_lsu.sv - blocking load/store unit between EXU and the core AXI bridge
module ysyx_00000000_lsu #(
    parameter bit MISALIGN_ERR = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_wen,
    input  logic [2:0]                 req_func3,
    input  logic [31:0]                req_addr,
    input  logic [31:0]                req_wdata,
    input  logic [4:0]                 req_rd,
    ysyx_00000000_lsu_if.master        bus,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [31:0]                wb_rdata,
    output logic [4:0]                 wb_rd,
    output logic                       wb_wen,
    output logic                       wb_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RADDR = 3'd1,
        RDATA = 3'd2,
        WREQ  = 3'd3,
        WRESP = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t      state;
    state_t      state_n;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [2:0]  func3_q;
    logic [4:0]  rd_q;
    logic        wen_q;
    logic        err_q;
    logic        aw_done;
    logic        w_done;

    logic        req_illegal;
    logic        misaligned;
    logic        bad_func3;
    logic [31:0] r_shift;
    logic [31:0] load_ext;
    logic [3:0]  strb_base;
    logic        aw_fire;
    logic        w_fire;

    assign aw_fire = bus.awvalid && bus.awready;
    assign w_fire  = bus.wvalid  && bus.wready;

    // Classify the incoming request; illegal ones never reach the bus
    always_comb begin
        misaligned = 1'b0;
        bad_func3  = 1'b0;
        case (req_func3[1:0])
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = 1'b0;
        endcase
        if (req_wen) begin
            bad_func3 = (req_func3 > 3'd2);
        end else begin
            bad_func3 = (req_func3 == 3'd3) || (req_func3 == 3'd6) || (req_func3 == 3'd7);
        end
        req_illegal = MISALIGN_ERR && (misaligned || bad_func3);
    end

    // Move the addressed lane down to bit 0 and extend according to func3
    always_comb begin
        r_shift  = bus.rdata >> {addr_q[1:0], 3'b000};
        load_ext = r_shift;
        case (func3_q)
            3'd0:    load_ext = {{24{r_shift[7]}}, r_shift[7:0]};
            3'd1:    load_ext = {{16{r_shift[15]}}, r_shift[15:0]};
            3'd4:    load_ext = {24'd0, r_shift[7:0]};
            3'd5:    load_ext = {16'd0, r_shift[15:0]};
            default: load_ext = r_shift;
        endcase
    end

    // Byte-enable pattern for the access size before lane positioning
    always_comb begin
        strb_base = 4'b1111;
        case (func3_q[1:0])
            2'd0:    strb_base = 4'b0001;
            2'd1:    strb_base = 4'b0011;
            default: strb_base = 4'b1111;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode; AW and W may complete in either order or together
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_illegal)  state_n = RESP;
                    else if (req_wen) state_n = WREQ;
                    else              state_n = RADDR;
                end
            end
            RADDR:   if (bus.arready) state_n = RDATA;
            RDATA:   if (bus.rvalid)  state_n = RESP;
            WREQ:    if ((aw_done || aw_fire) && (w_done || w_fire)) state_n = WRESP;
            WRESP:   if (bus.bvalid)  state_n = RESP;
            RESP:    if (wb_ready)    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Latch the request, capture bus responses and track write-channel progress
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            func3_q <= 3'd0;
            rd_q    <= 5'd0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        func3_q <= req_func3;
                        rd_q    <= req_rd;
                        wen_q   <= req_wen;
                        err_q   <= req_illegal;
                        rdata_q <= 32'd0;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                RDATA: begin
                    if (bus.rvalid) begin
                        err_q   <= (bus.rresp != 2'b00);
                        rdata_q <= (bus.rresp != 2'b00) ? 32'd0 : load_ext;
                    end
                end
                WREQ: begin
                    aw_done <= aw_done || aw_fire;
                    w_done  <= w_done  || w_fire;
                end
                WRESP: begin
                    if (bus.bvalid) begin
                        err_q <= (bus.bresp != 2'b00);
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = (state == IDLE);

    assign bus.arvalid = (state == RADDR);
    assign bus.araddr  = addr_q;
    assign bus.arsize  = {1'b0, func3_q[1:0]};
    assign bus.rready  = (state == RDATA);

    assign bus.awvalid = (state == WREQ) && !aw_done;
    assign bus.awaddr  = addr_q;
    assign bus.wvalid  = (state == WREQ) && !w_done;
    assign bus.wdata   = wdata_q << {addr_q[1:0], 3'b000};
    assign bus.wstrb   = (state == WREQ) ? (strb_base << addr_q[1:0]) : 4'b0000;
    assign bus.bready  = (state == WRESP);

    assign wb_valid    = (state == RESP);
    assign wb_err      = (state == RESP) && err_q;
    assign wb_rdata    = (state == RESP) ? rdata_q : 32'd0;
    assign wb_wen      = (state == RESP) && !wen_q && !err_q;
    assign wb_rd       = ((state == RESP) && !wen_q) ? rd_q : 5'd0;

endmodule

// File: tb/tb_ysyx_00000000_lsu.sv
// tb/tb_ysyx_00000000_lsu.sv - directed self-checking bench for the load/store unit
module tb_ysyx_00000000_lsu;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_rdata;
    logic [4:0]  wb_rd;
    logic        wb_wen;
    logic        wb_err;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_00000000_lsu_if bus ();

    ysyx_00000000_lsu dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_func3 (req_func3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_rd    (req_rd),
        .bus       (bus),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_rdata  (wb_rdata),
        .wb_rd     (wb_rd),
        .wb_wen    (wb_wen),
        .wb_err    (wb_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic wen, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_wen   = wen;
        req_func3 = f3;
        req_addr  = a;
        req_wdata = wd;
        req_rd    = rd;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic finish_resp(input string tag, input logic [31:0] exp_rdata, input logic [4:0] exp_rd,
                               input logic exp_wen, input logic exp_err, input int hold);
        check({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
        check({tag, "_wb_rdata"}, wb_rdata, exp_rdata);
        check({tag, "_wb_rd"},    32'(wb_rd), 32'(exp_rd));
        check({tag, "_wb_wen"},   32'(wb_wen), 32'(exp_wen));
        check({tag, "_wb_err"},   32'(wb_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_valid"}, 32'(wb_valid), 32'd1);
            check({tag, "_hold_rdata"}, wb_rdata, exp_rdata);
            check({tag, "_hold_rd"},    32'(wb_rd), 32'(exp_rd));
            check({tag, "_hold_err"},   32'(wb_err), 32'(exp_err));
            check({tag, "_hold_busy"},  32'(req_ready), 32'd0);
        end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        check({tag, "_done_valid"}, 32'(wb_valid), 32'd0);
        check({tag, "_done_ready"}, 32'(req_ready), 32'd1);
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                           input logic [31:0] rdata, input logic [1:0] rresp, input int ar_delay,
                           input logic [2:0] exp_size, input logic [31:0] exp_rdata, input logic exp_err,
                           input int hold);
        issue(1'b0, f3, a, 32'd0, rd);
        check({tag, "_arvalid"}, 32'(bus.arvalid), 32'd1);
        check({tag, "_araddr"},  bus.araddr, a);
        check({tag, "_arsize"},  32'(bus.arsize), 32'(exp_size));
        check({tag, "_awvalid"}, 32'(bus.awvalid), 32'd0);
        for (int i = 0; i < ar_delay; i++) begin
            tick();
            check({tag, "_ar_hold_valid"}, 32'(bus.arvalid), 32'd1);
            check({tag, "_ar_hold_addr"},  bus.araddr, a);
        end
        bus.arready = 1'b1;
        tick();
        bus.arready = 1'b0;
        check({tag, "_ar_drop"}, 32'(bus.arvalid), 32'd0);
        check({tag, "_rready"},  32'(bus.rready), 32'd1);
        bus.rvalid = 1'b1;
        bus.rdata  = rdata;
        bus.rresp  = rresp;
        tick();
        bus.rvalid = 1'b0;
        bus.rdata  = 32'd0;
        bus.rresp  = 2'b00;
        check({tag, "_rready_drop"}, 32'(bus.rready), 32'd0);
        finish_resp(tag, exp_rdata, rd, !exp_err, exp_err, hold);
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] exp_wdata, input logic [3:0] exp_strb, input logic [1:0] bresp,
                            input int w_lag, input logic exp_err);
        issue(1'b1, f3, a, wd, 5'd7);
        check({tag, "_awvalid"}, 32'(bus.awvalid), 32'd1);
        check({tag, "_wvalid"},  32'(bus.wvalid), 32'd1);
        check({tag, "_awaddr"},  bus.awaddr, a);
        check({tag, "_wdata"},   bus.wdata, exp_wdata);
        check({tag, "_wstrb"},   32'(bus.wstrb), 32'(exp_strb));
        check({tag, "_arvalid"}, 32'(bus.arvalid), 32'd0);
        if (w_lag == 0) begin
            bus.awready = 1'b1;
            bus.wready  = 1'b1;
            tick();
            bus.awready = 1'b0;
            bus.wready  = 1'b0;
        end else begin
            bus.awready = 1'b1;
            tick();
            bus.awready = 1'b0;
            check({tag, "_aw_drop"}, 32'(bus.awvalid), 32'd0);
            check({tag, "_w_keep"},  32'(bus.wvalid), 32'd1);
            for (int i = 0; i < w_lag - 1; i++) begin
                tick();
                check({tag, "_w_hold_valid"}, 32'(bus.wvalid), 32'd1);
                check({tag, "_w_hold_data"},  bus.wdata, exp_wdata);
                check({tag, "_w_hold_bready"}, 32'(bus.bready), 32'd0);
            end
            bus.wready = 1'b1;
            tick();
            bus.wready = 1'b0;
        end
        check({tag, "_aw_idle"}, 32'(bus.awvalid), 32'd0);
        check({tag, "_w_idle"},  32'(bus.wvalid), 32'd0);
        check({tag, "_bready"},  32'(bus.bready), 32'd1);
        bus.bvalid = 1'b1;
        bus.bresp  = bresp;
        tick();
        bus.bvalid = 1'b0;
        bus.bresp  = 2'b00;
        check({tag, "_bready_drop"}, 32'(bus.bready), 32'd0);
        finish_resp(tag, 32'd0, 5'd0, 1'b0, exp_err, 0);
    endtask

    task automatic do_illegal(input string tag, input logic wen, input logic [2:0] f3, input logic [31:0] a);
        issue(wen, f3, a, 32'h0000_0055, 5'd9);
        check({tag, "_arvalid"}, 32'(bus.arvalid), 32'd0);
        check({tag, "_awvalid"}, 32'(bus.awvalid), 32'd0);
        finish_resp(tag, 32'd0, wen ? 5'd0 : 5'd9, 1'b0, 1'b1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b0;
        req_valid   = 1'b0;
        req_wen     = 1'b0;
        req_func3   = 3'd0;
        req_addr    = 32'd0;
        req_wdata   = 32'd0;
        req_rd      = 5'd0;
        wb_ready    = 1'b0;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = 32'd0;
        bus.rresp   = 2'b00;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bresp   = 2'b00;
        tick();
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_arvalid",   32'(bus.arvalid), 32'd0);
        check("rst_rready",    32'(bus.rready), 32'd0);
        check("rst_awvalid",   32'(bus.awvalid), 32'd0);
        check("rst_wvalid",    32'(bus.wvalid), 32'd0);
        check("rst_bready",    32'(bus.bready), 32'd0);
        check("rst_wb_valid",  32'(wb_valid), 32'd0);
        check("rst_wb_rdata",  wb_rdata, 32'd0);
        check("rst_wb_err",    32'(wb_err), 32'd0);
        reset = 1'b1;
        tick();

        do_load("lw",  3'd2, 32'h8000_0004, 5'd5, 32'hDEAD_BEEF, 2'b00, 0, 3'd2, 32'hDEAD_BEEF, 1'b0, 0);
        do_load("lb",  3'd0, 32'h8000_0003, 5'd6, 32'h80AA_BBCC, 2'b00, 0, 3'd0, 32'hFFFF_FF80, 1'b0, 0);
        do_load("lbu", 3'd4, 32'h8000_0003, 5'd6, 32'h80AA_BBCC, 2'b00, 0, 3'd0, 32'h0000_0080, 1'b0, 0);
        do_store("sh", 3'd1, 32'h8000_0002, 32'h0000_1234, 32'h1234_0000, 4'b1100, 2'b00, 0, 1'b0);
        do_illegal("lw_mis", 1'b0, 3'd2, 32'h8000_0002);
        do_illegal("sb_f3",  1'b1, 3'd3, 32'h8000_0000);
        do_load("lh_ar5", 3'd1, 32'h8000_0006, 5'd11, 32'h8765_4321, 2'b00, 5, 3'd1, 32'hFFFF_8765, 1'b0, 0);
        do_load("lw_rerr", 3'd2, 32'h8000_0000, 5'd12, 32'h1111_2222, 2'b10, 0, 3'd2, 32'd0, 1'b1, 0);
        do_store("sw_wlag", 3'd2, 32'h8000_0010, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111, 2'b00, 2, 1'b0);
        do_load("lhu_wb3", 3'd5, 32'h8000_0002, 5'd13, 32'hBEEF_0000, 2'b00, 0, 3'd1, 32'h0000_BEEF, 1'b0, 3);
        do_store("sb_berr", 3'd0, 32'h8000_0001, 32'h0000_00AB, 32'h0000_AB00, 4'b0010, 2'b11, 0, 1'b1);

        issue(1'b0, 3'd2, 32'h8000_0001, 32'd0, 5'd4);
        check("wbr_wb_valid", 32'(wb_valid), 32'd1);
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_func3 = 3'd2;
        req_addr  = 32'h8000_0030;
        wb_ready  = 1'b1;
        tick();
        wb_ready  = 1'b0;
        req_valid = 1'b0;
        check("wbr_no_accept_ready", 32'(req_ready), 32'd1);
        check("wbr_no_accept_ar",    32'(bus.arvalid), 32'd0);
        check("wbr_wb_drop",         32'(wb_valid), 32'd0);

        issue(1'b0, 3'd2, 32'h8000_0020, 32'd0, 5'd3);
        bus.arready = 1'b1;
        tick();
        bus.arready = 1'b0;
        check("rst_mid_rready_before", 32'(bus.rready), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_mid_rready",   32'(bus.rready), 32'd0);
        check("rst_mid_req_rdy",  32'(req_ready), 32'd1);
        check("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_mid_arvalid",  32'(bus.arvalid), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("rst_after_req_rdy",  32'(req_ready), 32'd1);
        check("rst_after_rready",   32'(bus.rready), 32'd0);
        check("rst_after_wb_valid", 32'(wb_valid), 32'd0);
        do_load("lw_post_rst", 3'd2, 32'h8000_0024, 5'd8, 32'h0BAD_F00D, 2'b00, 0, 3'd2, 32'h0BAD_F00D, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
